// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stages: occupancy codes and the
// payload layouts carried across IF/ID, ID/EX, EX/MEM and MEM/WB.
package pipe_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ifid_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] rs1_val;
        logic [63:0] rs2_val;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [15:0] ctrl;
    } idex_t;

    typedef struct packed {
        logic [63:0] alu_res;
        logic [63:0] st_data;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } exmem_t;

    typedef struct packed {
        logic [63:0] wb_data;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
    } memwb_t;

    localparam int IFID_W  = $bits(ifid_t);
    localparam int IDEX_W  = $bits(idex_t);
    localparam int EXMEM_W = $bits(exmem_t);
    localparam int MEMWB_W = $bits(memwb_t);

    function automatic logic [1:0] occ_of(input logic head_v, input logic skid_v);
        case ({head_v, skid_v})
            2'b11:        occ_of = OCC_FULL;
            2'b10, 2'b01: occ_of = OCC_ONE;
            default:      occ_of = OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+data holding register; load/clear take effect next edge, clear wins.
// No flow control of its own: the owning stage decides when to load or clear.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);

    logic         vld_q;
    logic [W-1:0] dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
        end else if (clr_i) begin
            vld_q <= 1'b0;
        end else if (load_i) begin
            vld_q <= 1'b1;
        end
    end

    // Payload needs no reset: it is only observed while vld_q is set.
    always_ff @(posedge clk) begin
        if (load_i) begin
            dat_q <= d_i;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline register with optional skid entry; 1-cycle latency.
// SKID=1: in_ready is a flop (low only while skid is full); SKID=0: in_ready = !out_valid || out_ready.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    logic              head_vld, skid_vld, skid_nxt;
    logic [DATA_W-1:0] head_dat, skid_dat, head_din;
    logic              accept, emit, head_load, head_clr;
    logic              rdy_q;
    logic [CNT_W-1:0]  stall_q, stall_d;

    assign accept = in_valid && in_ready;
    assign emit   = head_vld && out_ready;

    // Draining the skid into the head takes precedence; in_ready is low then anyway.
    assign head_load = !flush && ((emit && skid_vld) || (accept && (!head_vld || emit)));
    assign head_clr  = flush || (emit && !head_load);
    assign head_din  = (emit && skid_vld) ? skid_dat : in_data;

    pipe_slot #(.W(DATA_W)) u_head (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (head_load),
        .clr_i  (head_clr),
        .d_i    (head_din),
        .vld_o  (head_vld),
        .dat_o  (head_dat)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic skid_load, skid_clr;
            assign skid_load = !flush && accept && head_vld && !emit;
            assign skid_clr  = flush || (emit && skid_vld);
            assign skid_nxt  = skid_load || (skid_vld && !skid_clr);

            pipe_slot #(.W(DATA_W)) u_skid (
                .clk    (clk),
                .rst_n  (rst_n),
                .load_i (skid_load),
                .clr_i  (skid_clr),
                .d_i    (in_data),
                .vld_o  (skid_vld),
                .dat_o  (skid_dat)
            );
        end else begin : g_noskid
            assign skid_vld = 1'b0;
            assign skid_dat = '0;
            assign skid_nxt = 1'b0;
        end
    endgenerate

    // rdy_q tracks !skid_vld one edge ahead and stays low while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= !skid_nxt;
        end
    end

    assign in_ready = (SKID != 0) ? rdy_q : (rdy_q && (!head_vld || out_ready));

    always_comb begin
        stall_d = stall_q;
        if (stall_clr) begin
            stall_d = '0;
        end else if (head_vld && !out_ready && !(&stall_q)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign out_valid = head_vld;
    assign out_data  = head_dat;
    assign occupancy = occ_of(head_vld, skid_vld);
    assign stall_cnt = stall_q;

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline stage register for the RV64 core. It replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches, which have only a write-enable and flush, with a valid/ready stage that has a two-entry skid buffer. Every stage boundary can then stall from downstream without a combinational ready path back through the whole pipe. Each instance carries an arbitrary payload (PC, instruction, control bits, operands) and supports a synchronous flush from branch resolution. It also provides a saturating stall-cycle counter for performance analysis.

## Interface
- DATA_W, 64: payload width in bits; legal range 1 or more.
- SKID, 1: 1 selects a two-entry skid buffer with a registered in_ready; 0 selects a single entry with in_ready = !out_valid || out_ready.
- CNT_W, 16: stall counter width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held entries (driven by branch-taken / PCsrc).
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  DATA_W  head payload.
- occupancy  out  2  number of held entries, 0..2 (0..1 when SKID=0).
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready; saturates at all-ones.
- stall_clr  in  1  synchronous clear of stall_cnt.

## Operation
- Storage: head entry (drives out_*) and, when SKID=1, a skid entry. Each entry holds a valid bit and DATA_W data bits.
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Emit occurs when out_valid && out_ready.
  - in_data must not be sampled unless in_ready is high.
- SKID=1 rules:
  - in_ready = !skid_valid, taken directly from a register.
  - Accept with head empty, or with head emitting: data goes to head.
  - Accept with head full and not emitting: data goes to skid.
  - Emit with skid full: skid moves to head and skid becomes empty.
  - Order is strictly FIFO and no entry is ever overwritten.
- SKID=0 rules:
  - Single head entry.
  - Simultaneous emit and accept replaces the head in the same cycle.
- Flush:
  - Next cycle, head_valid = skid_valid = 0.
  - An accept in the flush cycle completes the handshake, and its data is discarded.
  - Flush takes priority over every accept and emit state update.
  - Data registers need not clear; only valid bits matter.
- occupancy = head_valid + skid_valid.
- stall_cnt:
  - Increments on each cycle with out_valid && !out_ready, unless saturated.
  - stall_clr has priority over the increment.
  - Flush does not clear it.

## Timing
- Reset (rst_n=0, asynchronous): out_valid=0, occupancy=0, stall_cnt=0.
  - in_ready=0 while rst_n is low.
  - in_ready=1 from the first edge after rst_n deasserts.
- Latency: an accepted word appears on out_* in the next cycle when the stage was empty. Minimum latency is 1 cycle; there is no combinational in→out path.
- Throughput: 1 word/cycle sustained whenever out_ready stays high.
- SKID=1 ready timing: in_ready deasserts one cycle after the first cycle in which the head is full, out_ready is low and an accept occurs. It reasserts one cycle after the emit that drains the skid entry.
- Boundary cases:
  - Accept and emit in the same cycle with occupancy 1: occupancy stays 1 and head takes the new data.
  - Accept and emit with occupancy 2: cannot occur, because in_ready=0.
  - Emit with no accept at occupancy 2: occupancy becomes 1.
- Reset mid-transfer: all valid bits drop immediately and asynchronously, and any in-flight handshake is void.
- out_data holds stable while out_valid && !out_ready.

## Structure
- Shared package pipe_pkg holds:
  - the occupancy constants OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2;
  - the payload struct widths used by stage instances (IFID_W, IDEX_W, EXMEM_W, MEMWB_W).
- Sub-module pipe_slot: one valid+data register with load and clear enables and async reset of valid. It is instantiated once for the head, plus once for the skid when SKID=1.
- The hazard unit's stall maps onto de-asserting out_ready of the upstream stage, and flush maps to PCsrc.

## Test plan
- Reset, then in_valid=1 with data 0x1, 0x2, 0x3 on consecutive cycles and out_ready=1 -> out_data 0x1, 0x2, 0x3 on cycles 1, 2, 3; occupancy ≤ 1; stall_cnt=0.
- SKID=1, out_ready=0, offer 0xA, 0xB, 0xC -> 0xA and 0xB accepted, in_ready=0 on the third cycle, occupancy=2. Then out_ready=1 -> 0xA, 0xB, 0xC emitted in order with no loss.
- Occupancy 2, flush=1 for one cycle with in_valid=1 carrying data 0xD -> next cycle out_valid=0 and occupancy=0; 0xD never appears at the output.
- out_ready=0 for 5 cycles with head valid -> stall_cnt=5. Then stall_clr=1 while still stalled -> stall_cnt=0. With CNT_W=2 and 6 stalled cycles -> stall_cnt saturates at 3.
- rst_n pulled low asynchronously mid-cycle at occupancy 2 -> out_valid and in_ready low immediately. After release, the first accepted word is emitted with no stale data.
- SKID=0, out_ready toggling randomly with an in_valid stream 0..31 -> all 32 words emitted in order; in_ready equals !out_valid || out_ready every cycle.
